hex_keypad_entry: RTL and testbench
===================================

Name: hex_keypad_entry

Overview:
Input-side counterpart to the calculator's 7-segment display scanner. The block scans a 4x4 hex matrix keypad, debounces key presses, and emits one pulse with a 4-bit key code per press. It also shifts hex digits into the two 8-bit operand registers num1 and num2, which feed calculator_hex in place of the DIP switches.

Parameters:
SCAN_DIV, 100000, clk_g cycles per row slot. Must be >= 4; the bench uses 4.
DEBOUNCE_FRAMES, 3, consecutive identical scan frames required to accept a key state. Must be >= 1.

Ports:
clk_g  input  1  system clock, same as the display and calculator blocks
rst  input  1  asynchronous, active-low reset
key_col  input  4  keypad columns, active-low, pulled up, asynchronous to clk_g
target  input  1  0 = digits go to num1, 1 = digits go to num2
clr  input  1  synchronous clear of num1 and num2
key_row  output  4  keypad row drive, active-low, exactly one row low at a time
key_valid  output  1  one-cycle pulse on each accepted press
key_code  output  4  code of the last accepted key
num1  output  8  operand 1
num2  output  8  operand 2

Behaviour:
- Reset (rst=0, asynchronous): key_row=4'b1110, div_cnt=0, row_idx=0, debounced=NONE, candidate=NONE, stable_cnt=0, key_valid=0, key_code=0, num1=0, num2=0. Both synchronizer stages are set to 4'b1111.
- key_col passes through a 2-flop synchronizer; col_s is the synchronized value.
- Scan:
  - div_cnt counts 0..SCAN_DIV-1 and wraps.
  - On the edge where div_cnt==SCAN_DIV-1, col_s is sampled for the current row, then row_idx advances 0->1->2->3->0.
  - key_row = ~(4'b0001<<row_idx) and updates on that same edge.
- Row hit: if the sampled col_s != 4'b1111, the hit column is the lowest index c with col_s[c]==0, and the hit code is {row_idx[1:0], c[1:0]}.
- Frame: four row samples, rows 0..3. The frame result is the hit from the lowest-numbered row that had a hit, or NONE. Multi-key presses therefore resolve deterministically: lowest row first, then lowest column.
- Frame end is the sample edge of row 3. At frame end:
  - If the frame result == candidate: stable_cnt = min(stable_cnt+1, DEBOUNCE_FRAMES).
  - Otherwise: candidate = frame result and stable_cnt = 1.
  - Then, if the updated stable_cnt == DEBOUNCE_FRAMES and candidate != debounced: debounced = candidate.
- Press event: debounced changes to a key value, either from NONE or from a different key. On that same edge:
  - key_valid <= 1 for exactly one cycle, and key_code <= new key.
  - If target==0: num1 <= {num1[3:0], key_code_new}. Otherwise: num2 <= {num2[3:0], key_code_new}.
- Changing to NONE (release) produces no pulse and no shift.
- A held key produces exactly one pulse. Auto-repeat is not supported.
- key_valid is 0 on all other cycles.
- clr=1 on an edge sets num1=num2=0 and takes priority over a shift on the same edge. The key_valid pulse and key_code update still occur; only the shift is suppressed. clr does not affect scan or debounce state.
- target is sampled only on the press edge.
- Bounces shorter than DEBOUNCE_FRAMES frames never change debounced.
- Reset mid-scan or mid-debounce returns everything to reset values immediately. A key held across reset release is reported as a fresh press after DEBOUNCE_FRAMES frames.
- Timing, counting edge 1 as the first rising edge after rst goes high:
  - Row r of frame n is sampled at edge 4*SCAN_DIV*(n-1) + SCAN_DIV*(r+1).
  - Frame n ends at edge 4*SCAN_DIV*n.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE_FRAMES=3. Keypad model shorts row 1 to col 2 (key 6) from reset release and holds it. Required: key_valid high exactly once, asserted at edge 48, with key_code=4'h6 and num1=8'h06; no further pulse within 200 cycles.
2. With target=0, press and release 3, then A, each held 4 frames with 4 released frames between. Then set target=1 and press F. Required: num1=8'h3A, num2=8'h0F, exactly 3 key_valid pulses.
3. Key 5 toggles in bursts: held 1 frame, released 1 frame, repeated 5 times. Then held 3 frames. Required: no pulse during the bursts; exactly one pulse with key_code=5 after the third stable frame.
4. Keys 9 and 2 pressed simultaneously. Required: key_code=4'h2 (row 0 wins). Then 2 is released while 9 stays held. Required: after 3 frames a second pulse with key_code=4'h9.
5. num1=8'h3A and clr is asserted on the same edge as a press of key 7. Required: num1=8'h00 after the edge, key_valid=1, key_code=7. The next press of 4 gives num1=8'h04.
6. rst pulsed low during frame 2 of a key-B press. Required: all outputs return to reset values immediately (key_row=4'b1110). After release of rst, key_valid asserts at edge 48 with code 4'hB.

Source files
------------

// File: rtl/hex_keypad_entry.sv
// 4x4 hex keypad scanner with frame-based debounce and two shift-in operand registers.
// One press emits a single key_valid pulse and shifts its digit into num1 or num2.
module hex_keypad_entry #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk_g,
    input  logic       rst,
    input  logic [3:0] key_col,
    input  logic       target,
    input  logic       clr,
    output logic [3:0] key_row,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [7:0] num1,
    output logic [7:0] num2
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_FRAMES);
    // Key values carry a presence bit on top of the 4-bit code; all-zero means no key.
    localparam logic [4:0] KEY_NONE = 5'b0_0000;

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       row_nxt;
    logic [4:0]       frame_acc;
    logic [4:0]       row_hit;
    logic [4:0]       frame_result;
    logic [4:0]       candidate;
    logic [4:0]       cand_nxt;
    logic [4:0]       debounced;
    logic [STB_W-1:0] stable_cnt;
    logic [STB_W-1:0] stable_nxt;
    logic             sample;
    logic             frame_end;
    logic             accept;
    logic             press;

    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= key_col;
            col_s    <= col_meta;
        end
    end

    assign sample    = (div_cnt == DIV_LAST);
    assign frame_end = sample && (row_idx == 2'd3);
    assign row_nxt   = row_idx + 2'd1;

    // Descending loop so the lowest asserted column wins.
    always_comb begin
        row_hit = KEY_NONE;
        for (int c = 3; c >= 0; c--) begin
            if (!col_s[c]) row_hit = {1'b1, row_idx, 2'(c)};
        end
    end

    assign frame_result = frame_acc[4] ? frame_acc : row_hit;

    always_comb begin
        cand_nxt   = candidate;
        stable_nxt = stable_cnt;
        if (frame_result == candidate) begin
            if (stable_cnt < STB_MAX) stable_nxt = stable_cnt + 1'b1;
        end else begin
            cand_nxt   = frame_result;
            stable_nxt = STB_W'(1);
        end
        accept = frame_end && (stable_nxt == STB_MAX) && (cand_nxt != debounced);
        press  = accept && cand_nxt[4];
    end

    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            row_idx   <= 2'd0;
            key_row   <= 4'b1110;
            frame_acc <= KEY_NONE;
        end else begin
            div_cnt <= sample ? '0 : div_cnt + 1'b1;
            if (sample) begin
                row_idx <= row_nxt;
                key_row <= ~(4'b0001 << row_nxt);
                if (row_idx == 2'd3) frame_acc <= KEY_NONE;
                else if (!frame_acc[4]) frame_acc <= row_hit;
            end
        end
    end

    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            candidate  <= KEY_NONE;
            stable_cnt <= '0;
            debounced  <= KEY_NONE;
        end else if (frame_end) begin
            candidate  <= cand_nxt;
            stable_cnt <= stable_nxt;
            if (accept) debounced <= cand_nxt;
        end
    end

    // clr wins over the shift but never masks the pulse or the code update.
    always_ff @(posedge clk_g or negedge rst) begin
        if (!rst) begin
            key_valid <= 1'b0;
            key_code  <= 4'h0;
            num1      <= 8'h00;
            num2      <= 8'h00;
        end else begin
            key_valid <= press;
            if (press) key_code <= cand_nxt[3:0];
            if (clr) begin
                num1 <= 8'h00;
                num2 <= 8'h00;
            end else if (press) begin
                if (!target) num1 <= {num1[3:0], cand_nxt[3:0]};
                else         num2 <= {num2[3:0], cand_nxt[3:0]};
            end
        end
    end

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: a keypad model shorts rows to columns,
// stimulus queues expected pulses, and a negedge monitor pops and compares them.
module tb_hex_keypad_entry;

    logic       clk_g = 1'b0;
    logic       rst;
    logic [3:0] key_col;
    logic       target;
    logic       clr;
    logic [3:0] key_row;
    logic       key_valid;
    logic [3:0] key_code;
    logic [7:0] num1;
    logic [7:0] num2;

    logic [15:0] pressed;
    int          edge_cnt;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [3:0] code;
        logic [7:0] n1;
        logic [7:0] n2;
        int         at_edge;
    } exp_t;

    exp_t exp_q[$];

    hex_keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk_g     (clk_g),
        .rst       (rst),
        .key_col   (key_col),
        .target    (target),
        .clr       (clr),
        .key_row   (key_row),
        .key_valid (key_valid),
        .key_code  (key_code),
        .num1      (num1),
        .num2      (num2)
    );

    always #5 clk_g = ~clk_g;

    always_comb begin
        key_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!key_row[r] && pressed[r*4+c]) key_col[c] = 1'b0;
    end

    always @(posedge clk_g or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    always @(negedge clk_g) begin
        exp_t e;
        if (rst && key_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got key_code %0h at edge %0d, required no pulse",
                         key_code, edge_cnt);
            end else begin
                e = exp_q.pop_front();
                check("pulse_code", 32'(key_code), 32'(e.code));
                check("pulse_num1", 32'(num1), 32'(e.n1));
                check("pulse_num2", 32'(num2), 32'(e.n2));
                if (e.at_edge >= 0) check("pulse_edge", 32'(edge_cnt), 32'(e.at_edge));
            end
        end
    end

    function automatic logic [15:0] kb(input int k);
        logic [15:0] one;
        one = 16'h0001;
        return one << k;
    endfunction

    task automatic push(input logic [3:0] code, input logic [7:0] n1, input logic [7:0] n2,
                        input int at_edge);
        exp_t e;
        e.code = code; e.n1 = n1; e.n2 = n2; e.at_edge = at_edge;
        exp_q.push_back(e);
    endtask

    task automatic hold(input logic [15:0] k, input int frames);
        pressed = k;
        repeat (16 * frames) @(negedge clk_g);
    endtask

    task automatic align;
        while (edge_cnt % 16 != 0) @(negedge clk_g);
    endtask

    initial begin
        int e0;
        rst     = 1'b0;
        target  = 1'b0;
        clr     = 1'b0;
        pressed = kb(6);
        repeat (3) @(negedge clk_g);
        check("rst_key_row", 32'(key_row), 32'h0E);
        check("rst_key_valid", 32'(key_valid), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        check("rst_num1", 32'(num1), 32'h00);
        check("rst_num2", 32'(num2), 32'h00);

        // Key 6 held from reset release
        push(4'h6, 8'h06, 8'h00, 48);
        rst = 1'b1;
        repeat (250) @(negedge clk_g);
        check("drain_t1", 32'(exp_q.size()), 32'd0);
        pressed = '0;
        repeat (80) @(negedge clk_g);
        clr = 1'b1;
        @(negedge clk_g);
        clr = 1'b0;
        check("clr_idle_num1", 32'(num1), 32'h00);

        // Digit entry into num1 then num2
        align();
        push(4'h3, 8'h03, 8'h00, edge_cnt + 48);
        hold(kb(3), 4);
        hold('0, 4);
        push(4'hA, 8'h3A, 8'h00, edge_cnt + 48);
        hold(kb(10), 4);
        hold('0, 4);
        target = 1'b1;
        push(4'hF, 8'h3A, 8'h0F, edge_cnt + 48);
        hold(kb(15), 4);
        hold('0, 4);
        check("t2_num1", 32'(num1), 32'h3A);
        check("t2_num2", 32'(num2), 32'h0F);
        check("drain_t2", 32'(exp_q.size()), 32'd0);

        // Bouncing key 5 then a clean 3-frame hold
        for (int i = 0; i < 5; i++) begin
            hold(kb(5), 1);
            hold('0, 1);
        end
        push(4'h5, 8'h3A, 8'hF5, edge_cnt + 48);
        hold(kb(5), 3);
        hold('0, 5);
        check("drain_t3", 32'(exp_q.size()), 32'd0);

        // 9 and 2 together: row 0 wins, then 9 alone
        push(4'h2, 8'h3A, 8'h52, edge_cnt + 48);
        hold(kb(9) | kb(2), 4);
        push(4'h9, 8'h3A, 8'h29, edge_cnt + 48);
        hold(kb(9), 4);
        hold('0, 5);
        check("drain_t4", 32'(exp_q.size()), 32'd0);

        // clr coincident with a press of 7
        target = 1'b0;
        e0 = edge_cnt;
        push(4'h7, 8'h00, 8'h00, e0 + 48);
        pressed = kb(7);
        while (edge_cnt < e0 + 47) @(negedge clk_g);
        clr = 1'b1;
        @(negedge clk_g);
        clr = 1'b0;
        check("t5_clr_num1", 32'(num1), 32'h00);
        check("t5_clr_valid", 32'(key_valid), 32'h1);
        repeat (16) @(negedge clk_g);
        hold('0, 4);
        push(4'h4, 8'h04, 8'h00, edge_cnt + 48);
        hold(kb(4), 4);
        hold('0, 4);
        check("t5_num1", 32'(num1), 32'h04);
        check("drain_t5", 32'(exp_q.size()), 32'd0);

        // Reset during frame 2 of a B press
        pressed = kb(11);
        repeat (20) @(negedge clk_g);
        rst = 1'b0;
        #1;
        check("midrst_key_row", 32'(key_row), 32'h0E);
        check("midrst_key_valid", 32'(key_valid), 32'h0);
        check("midrst_key_code", 32'(key_code), 32'h0);
        check("midrst_num1", 32'(num1), 32'h00);
        check("midrst_num2", 32'(num2), 32'h00);
        repeat (3) @(negedge clk_g);
        push(4'hB, 8'h0B, 8'h00, 48);
        rst = 1'b1;
        repeat (100) @(negedge clk_g);
        pressed = '0;
        repeat (80) @(negedge clk_g);
        check("drain_t6", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
